// File: rtl/obi_fetch_stream.sv
// Read-only OBI manager: fetches a run of sequential words from SRAM and
// returns them as a valid/ready stream with a last marker.
module obi_fetch_stream #(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned LenWidth       = 16,
  parameter int unsigned FifoDepth      = 4,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [AddrWidth-1:0]   base_addr_i,
  input  logic [LenWidth-1:0]    len_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   err_o,
  output logic                   obi_req_o,
  input  logic                   obi_gnt_i,
  output logic [AddrWidth-1:0]   obi_addr_o,
  output logic                   obi_we_o,
  output logic [DataWidth/8-1:0] obi_be_o,
  output logic [DataWidth-1:0]   obi_wdata_o,
  input  logic                   obi_rvalid_i,
  input  logic [DataWidth-1:0]   obi_rdata_i,
  input  logic                   obi_err_i,
  output logic                   data_valid_o,
  input  logic                   data_ready_i,
  output logic [DataWidth-1:0]   data_o,
  output logic                   data_last_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW = $clog2(FifoDepth + 1);
  localparam int unsigned OutW = $clog2(MaxOutstanding + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam logic [AddrWidth-1:0] Stride = AddrWidth'(DataWidth / 8);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   addr_q;
  logic [LenWidth-1:0]    req_left_q;
  logic [LenWidth-1:0]    pop_left_q;
  logic [OutW-1:0]        outst_q;
  logic [CntW-1:0]        count_q;
  logic [PtrW-1:0]        wptr_q;
  logic [PtrW-1:0]        rptr_q;
  logic [DataWidth-1:0]   mem_q [FifoDepth];
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;

  logic                   req;
  logic                   gnt_fire;
  logic                   push;
  logic                   pop;
  logic                   start_ok;
  logic [SumW-1:0]        credit_sum;

  // Every granted read reserves a FIFO slot, so a response always has room.
  // Credits only shrink on a grant, which keeps an asserted request stable.
  always_comb begin
    credit_sum = SumW'(outst_q) + SumW'(count_q);
    req        = (state_q == FETCH) && (req_left_q != '0)
                 && (outst_q < OutW'(MaxOutstanding))
                 && (credit_sum < SumW'(FifoDepth));
    gnt_fire   = req && obi_gnt_i;
    pop        = (count_q != '0) && data_ready_i;
    push       = obi_rvalid_i && ((count_q != CntW'(FifoDepth)) || pop);
    start_ok   = start_i && !busy_q && (state_q == IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      req_left_q <= '0;
      pop_left_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (obi_rvalid_i && obi_err_i) begin
        err_q <= 1'b1;
      end
      if (pop && (pop_left_q != '0)) begin
        pop_left_q <= pop_left_q - LenWidth'(1);
      end
      unique case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (start_ok) begin
            err_q <= 1'b0;
            if (len_i != '0) begin
              addr_q     <= base_addr_i;
              req_left_q <= len_i;
              pop_left_q <= len_i;
              busy_q     <= 1'b1;
              state_q    <= FETCH;
            end else begin
              // Empty transfer: one-cycle busy/done pulse, no bus traffic.
              busy_q <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (gnt_fire) begin
            addr_q     <= addr_q + Stride;
            req_left_q <= req_left_q - LenWidth'(1);
            if (req_left_q == LenWidth'(1)) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop_left_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outst_q <= '0;
    end else begin
      unique case ({gnt_fire, obi_rvalid_i})
        2'b10:   outst_q <= outst_q + OutW'(1);
        2'b01:   if (outst_q != '0) outst_q <= outst_q - OutW'(1);
        default: outst_q <= outst_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wptr_q] <= obi_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign obi_req_o    = req;
  assign obi_addr_o   = addr_q;
  assign obi_we_o     = 1'b0;
  assign obi_be_o     = '1;
  assign obi_wdata_o  = '0;
  assign data_valid_o = (count_q != '0);
  assign data_o       = mem_q[rptr_q];
  assign data_last_o  = data_valid_o && (pop_left_q == LenWidth'(1));

endmodule
